// File: rtl/sema_seq_ctrl_if.sv
// Signal bundle between the semaphore sequencer and its environment: raw requests
// and decoder results in, registered state/requests/lamps out.
interface sema_seq_ctrl_if;
    logic       p_btn;
    logic       w_sens;
    logic       s_sens;
    logic [3:0] next_st;
    logic [2:0] w_gyr_in;
    logic [2:0] s_gyr_in;
    logic [1:0] p_gr_in;

    logic [3:0] curr_st;
    logic       p_req;
    logic       w_req;
    logic       s_req;
    logic [2:0] w_gyr;
    logic [2:0] s_gyr;
    logic [1:0] p_gr;
    logic       step;

    modport master (
        output p_btn, w_sens, s_sens, next_st, w_gyr_in, s_gyr_in, p_gr_in,
        input  curr_st, p_req, w_req, s_req, w_gyr, s_gyr, p_gr, step
    );

    modport slave (
        input  p_btn, w_sens, s_sens, next_st, w_gyr_in, s_gyr_in, p_gr_in,
        output curr_st, p_req, w_req, s_req, w_gyr, s_gyr, p_gr, step
    );
endinterface

// File: rtl/sema_seq_ctrl.sv
// Sequential half of the traffic semaphore: state/lamp registers, sticky request
// latches, tick prescaler and per-state dwell timer feeding an external decoder.
module sema_seq_ctrl #(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned GREEN_TICKS  = 10,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned PED_TICKS    = 8,
    parameter int unsigned BLINK_TICKS  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sema_seq_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [7:0] DW_GREEN  = 8'(GREEN_TICKS);
    localparam logic [7:0] DW_YELLOW = 8'(YELLOW_TICKS);
    localparam logic [7:0] DW_PED    = 8'(PED_TICKS);
    localparam logic [7:0] DW_BLINK  = 8'(BLINK_TICKS);

    localparam logic [3:0] ST_W_GREEN   = 4'd0;
    localparam logic [3:0] ST_S_GREEN   = 4'd3;
    localparam logic [3:0] ST_P_GREEN_W = 4'd6;
    localparam logic [3:0] ST_P_GREEN_S = 4'd7;

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    dwell_q, dwell_d;
    logic [3:0]    st_q, st_d;
    logic [2:0]    w_gyr_q, w_gyr_d;
    logic [2:0]    s_gyr_q, s_gyr_d;
    logic [1:0]    p_gr_q, p_gr_d;
    logic          p_req_q, p_req_d;
    logic          w_req_q, w_req_d;
    logic          s_req_q, s_req_d;
    logic          step_q, step_d;

    logic tick;
    logic expired;
    logic advance;

    function automatic logic [7:0] dwell_of(input logic [3:0] st);
        logic [7:0] d;
        case (st)
            4'd0, 4'd3:             d = DW_GREEN;
            4'd1, 4'd2, 4'd4, 4'd5: d = DW_YELLOW;
            4'd6, 4'd7:             d = DW_PED;
            default:                d = DW_BLINK;
        endcase
        return d;
    endfunction

    assign tick    = (presc_q == PRESC_MAX);
    assign expired = (dwell_q <= 8'd1);
    // A step whose target equals the current state is a no-op, so green holds
    // with the dwell parked at 1 and the attempt repeats every tick.
    assign advance = tick && expired && (bus.next_st != st_q);

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        dwell_d = dwell_q;
        st_d    = st_q;
        w_gyr_d = w_gyr_q;
        s_gyr_d = s_gyr_q;
        p_gr_d  = p_gr_q;
        step_d  = advance;

        if (tick && !expired) begin
            dwell_d = dwell_q - 8'd1;
        end

        if (advance) begin
            st_d    = bus.next_st;
            w_gyr_d = bus.w_gyr_in;
            s_gyr_d = bus.s_gyr_in;
            p_gr_d  = bus.p_gr_in;
            dwell_d = dwell_of(bus.next_st);
        end

        // Set has priority over the clear taken on entry to the serving state.
        w_req_d = bus.w_sens | (w_req_q & ~(advance && bus.next_st == ST_W_GREEN));
        s_req_d = bus.s_sens | (s_req_q & ~(advance && bus.next_st == ST_S_GREEN));
        p_req_d = bus.p_btn  | (p_req_q & ~(advance && (bus.next_st == ST_P_GREEN_W ||
                                                         bus.next_st == ST_P_GREEN_S)));
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            dwell_q <= DW_GREEN;
            st_q    <= ST_W_GREEN;
            w_gyr_q <= 3'b100;
            s_gyr_q <= 3'b001;
            p_gr_q  <= 2'b01;
            p_req_q <= 1'b0;
            w_req_q <= 1'b0;
            s_req_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            dwell_q <= dwell_d;
            st_q    <= st_d;
            w_gyr_q <= w_gyr_d;
            s_gyr_q <= s_gyr_d;
            p_gr_q  <= p_gr_d;
            p_req_q <= p_req_d;
            w_req_q <= w_req_d;
            s_req_q <= s_req_d;
            step_q  <= step_d;
        end
    end

    assign bus.curr_st = st_q;
    assign bus.p_req   = p_req_q;
    assign bus.w_req   = w_req_q;
    assign bus.s_req   = s_req_q;
    assign bus.w_gyr   = w_gyr_q;
    assign bus.s_gyr   = s_gyr_q;
    assign bus.p_gr    = p_gr_q;
    assign bus.step    = step_q;
endmodule

// File: tb/tb_sema_seq_ctrl.sv
// Bench for sema_seq_ctrl: small reference decoder drives next_st/lamps, an
// abstract cycle model predicts every output, directed scenarios pin the model.
module tb_sema_seq_ctrl;
    localparam int TICK_DIV = 4;
    localparam int GREEN    = 3;
    localparam int YELLOW   = 2;
    localparam int PED      = 4;
    localparam int BLINK    = 1;

    logic clk;
    logic rst_n;
    sema_seq_ctrl_if bus ();

    sema_seq_ctrl #(
        .TICK_DIV(TICK_DIV), .GREEN_TICKS(GREEN), .YELLOW_TICKS(YELLOW),
        .PED_TICKS(PED), .BLINK_TICKS(BLINK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit rand_dec = 1'b0;

    // Model state: what the block must present after each edge.
    logic [3:0] m_st;
    logic [2:0] m_w, m_s;
    logic [1:0] m_p;
    logic       m_preq, m_wreq, m_sreq, m_step;
    int         m_presc, m_dwell;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    function automatic int dwell_of(input logic [3:0] st);
        if (st == 0 || st == 3) return GREEN;
        if (st == 1 || st == 2 || st == 4 || st == 5) return YELLOW;
        if (st == 6 || st == 7) return PED;
        return BLINK;
    endfunction

    // Reference decoder: route choice from state and latched requests.
    function automatic logic [3:0] dec_next(input logic [3:0] st, input logic p, input logic w,
                                            input logic s);
        case (st)
            4'd0:    return s ? 4'd1 : (p ? 4'd2 : 4'd0);
            4'd1:    return 4'd3;
            4'd2:    return 4'd6;
            4'd3:    return w ? 4'd4 : (p ? 4'd5 : 4'd3);
            4'd4:    return 4'd0;
            4'd5:    return 4'd7;
            4'd6:    return (w || s) ? 4'd12 : 4'd6;
            4'd7:    return (w || s) ? 4'd8 : 4'd7;
            4'd11:   return 4'd3;
            4'd15:   return 4'd0;
            default: return st + 4'd1;
        endcase
    endfunction

    task automatic lamps_of(input logic [3:0] st, output logic [2:0] wl, output logic [2:0] sl,
                            output logic [1:0] pl);
        wl = 3'b001; sl = 3'b001; pl = 2'b01;
        if (st == 0) wl = 3'b100;
        else if (st == 1 || st == 2) wl = 3'b010;
        else if (st == 3) sl = 3'b100;
        else if (st == 4 || st == 5) sl = 3'b010;
        else if (st == 6 || st == 7) pl = 2'b10;
        else pl = st[0] ? 2'b10 : 2'b00;
    endtask

    task automatic model_step();
        bit tick, adv;
        logic [3:0] nx;
        if (!rst_n) begin
            m_st = 4'd0; m_w = 3'b100; m_s = 3'b001; m_p = 2'b01;
            m_preq = 0; m_wreq = 0; m_sreq = 0; m_step = 0;
            m_presc = 0; m_dwell = GREEN;
            return;
        end
        nx   = bus.next_st;
        tick = (m_presc == TICK_DIV - 1);
        adv  = tick && m_dwell <= 1 && nx != m_st;
        m_wreq = bus.w_sens || (m_wreq && !(adv && nx == 0));
        m_sreq = bus.s_sens || (m_sreq && !(adv && nx == 3));
        m_preq = bus.p_btn  || (m_preq && !(adv && (nx == 6 || nx == 7)));
        m_step = adv;
        m_presc = tick ? 0 : m_presc + 1;
        if (tick && m_dwell > 1) m_dwell--;
        if (adv) begin
            m_st = nx; m_w = bus.w_gyr_in; m_s = bus.s_gyr_in; m_p = bus.p_gr_in;
            m_dwell = dwell_of(nx);
        end
    endtask

    // Compare process: every cycle after the first edge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("curr_st", bus.curr_st, m_st);
            check("w_gyr",   bus.w_gyr,   m_w);
            check("s_gyr",   bus.s_gyr,   m_s);
            check("p_gr",    bus.p_gr,    m_p);
            check("p_req",   bus.p_req,   m_preq);
            check("w_req",   bus.w_req,   m_wreq);
            check("s_req",   bus.s_req,   m_sreq);
            check("step",    bus.step,    m_step);
        end
    end

    // One clock: drive inputs, advance the model, take the edge, land on the falling edge.
    task automatic edge_cycle(input bit rst, input logic p, input logic w, input logic s);
        logic [3:0] nx;
        logic [2:0] wl, sl;
        logic [1:0] pl;
        if (rand_dec) begin
            nx = 4'($urandom_range(15));
            wl = 3'($urandom_range(7)); sl = 3'($urandom_range(7)); pl = 2'($urandom_range(3));
        end else begin
            nx = dec_next(bus.curr_st, bus.p_req, bus.w_req, bus.s_req);
            lamps_of(nx, wl, sl, pl);
        end
        rst_n = ~rst;
        bus.p_btn = p; bus.w_sens = w; bus.s_sens = s;
        bus.next_st = nx; bus.w_gyr_in = wl; bus.s_gyr_in = sl; bus.p_gr_in = pl;
        #1;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc = rst ? -1 : cyc + 1;
        chk_en = 1'b1;
    endtask

    task automatic do_reset();
        edge_cycle(1, 0, 0, 0);
        edge_cycle(1, 0, 0, 0);
    endtask

    task automatic idle_until(input int c);
        int guard = 0;
        while (cyc < c && guard < 1000) begin
            edge_cycle(0, 0, 0, 0);
            guard++;
        end
    endtask

    task automatic wait_state(input string name, input logic [3:0] target, output int n);
        n = 0;
        while (bus.curr_st != target && n < 200) begin
            edge_cycle(0, 0, 0, 0);
            n++;
        end
        check(name, bus.curr_st, target);
    endtask

    initial begin
        int n;
        bit seen;
        rst_n = 1'b0;
        bus.p_btn = 0; bus.w_sens = 0; bus.s_sens = 0;
        bus.next_st = 0; bus.w_gyr_in = 0; bus.s_gyr_in = 0; bus.p_gr_in = 0;

        // Reset and a long quiet period: parked in west green, no step pulses.
        do_reset();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            edge_cycle(0, 0, 0, 0);
            if (bus.step) seen = 1;
        end
        check("quiet_no_step", 8'(seen), 8'd0);
        check("quiet_st", bus.curr_st, 4'd0);
        check("quiet_w", bus.w_gyr, 3'b100);
        check("quiet_s", bus.s_gyr, 3'b001);
        check("quiet_p", bus.p_gr, 2'b01);

        // South pulse at cycle 1: step to 1 on tick 11, to 3 on tick 19.
        do_reset();
        edge_cycle(0, 0, 0, 0);
        edge_cycle(0, 0, 0, 1);
        check("s_req_set", bus.s_req, 1'b1);
        idle_until(10);
        check("s_before_tick", bus.curr_st, 4'd0);
        idle_until(11);
        check("s_st1", bus.curr_st, 4'd1);
        check("s_st1_w", bus.w_gyr, 3'b010);
        check("s_st1_step", bus.step, 1'b1);
        idle_until(19);
        check("s_st3", bus.curr_st, 4'd3);
        check("s_st3_s", bus.s_gyr, 3'b100);
        check("s_st3_w", bus.w_gyr, 3'b001);
        check("s_st3_req", bus.s_req, 1'b0);

        // Pedestrian: 0->2->6, then west request through blink 12..15 back to 0.
        do_reset();
        edge_cycle(0, 0, 0, 0);
        edge_cycle(0, 1, 0, 0);
        wait_state("p_to2", 4'd2, n);
        wait_state("p_to6", 4'd6, n);
        check("p6_pgr", bus.p_gr, 2'b10);
        check("p6_preq", bus.p_req, 1'b0);
        edge_cycle(0, 0, 1, 0);
        wait_state("b_to12", 4'd12, n);
        check("b12_pgr", bus.p_gr, 2'b00);
        wait_state("b_to13", 4'd13, n);
        check("b13_len", 8'(n), 8'(TICK_DIV));
        check("b13_pgr", bus.p_gr, 2'b10);
        wait_state("b_to14", 4'd14, n);
        check("b14_pgr", bus.p_gr, 2'b00);
        wait_state("b_to15", 4'd15, n);
        check("b15_pgr", bus.p_gr, 2'b10);
        wait_state("b_to0", 4'd0, n);
        check("b0_len", 8'(n), 8'(TICK_DIV));
        check("b0_w", bus.w_gyr, 3'b100);
        check("b0_p", bus.p_gr, 2'b01);
        check("b0_wreq", bus.w_req, 1'b0);

        // South and pedestrian together: south first, pedestrian afterwards.
        do_reset();
        edge_cycle(0, 0, 0, 0);
        edge_cycle(0, 1, 0, 1);
        wait_state("sp_to1", 4'd1, n);
        wait_state("sp_to3", 4'd3, n);
        check("sp3_preq", bus.p_req, 1'b1);
        wait_state("sp_to5", 4'd5, n);
        check("sp5_len", 8'(n), 8'(GREEN * TICK_DIV));
        wait_state("sp_to7", 4'd7, n);
        check("sp7_preq", bus.p_req, 1'b0);

        // South held through entry to 3: the request survives its own clear.
        do_reset();
        n = 0;
        while (bus.curr_st != 4'd3 && n < 200) begin
            edge_cycle(0, 0, 0, 1);
            n++;
        end
        check("hold_st3", bus.curr_st, 4'd3);
        check("hold_sreq", bus.s_req, 1'b1);
        edge_cycle(0, 0, 1, 0);
        wait_state("hold_to4", 4'd4, n);

        // Reset mid-blink with a pending pedestrian request.
        do_reset();
        edge_cycle(0, 1, 0, 0);
        wait_state("r_to6", 4'd6, n);
        edge_cycle(0, 0, 1, 0);
        wait_state("r_to12", 4'd12, n);
        edge_cycle(0, 1, 0, 0);
        wait_state("r_to13", 4'd13, n);
        check("r13_preq", bus.p_req, 1'b1);
        edge_cycle(1, 0, 0, 0);
        check("r_st", bus.curr_st, 4'd0);
        check("r_w", bus.w_gyr, 3'b100);
        check("r_s", bus.s_gyr, 3'b001);
        check("r_p", bus.p_gr, 2'b01);
        check("r_reqs", {bus.p_req, bus.w_req, bus.s_req}, 3'b000);
        check("r_step", bus.step, 1'b0);
        edge_cycle(0, 0, 0, 1);
        wait_state("r_restart", 4'd1, n);
        check("r_restart_len", 8'(n), 8'(GREEN * TICK_DIV - 1));

        // Random requests with the reference decoder.
        for (int i = 0; i < 3000; i++) begin
            edge_cycle($urandom_range(499) == 0, $urandom_range(19) == 0,
                       $urandom_range(19) == 0, $urandom_range(19) == 0);
        end

        // Random decoder outputs: arbitrary next states and lamp codes.
        rand_dec = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            edge_cycle($urandom_range(299) == 0, $urandom_range(7) == 0,
                       $urandom_range(7) == 0, $urandom_range(7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
